// File: rtl/note_mixer_if.sv
// Codec-side audio bus: sample pair, write strobe and FIFO-space handshake.
// The mixer is the master; the codec FIFO (or testbench) is the slave.
interface note_mixer_if;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic [7:0]  dropped_count;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out,
    output dropped_count
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  dropped_count
  );
endinterface

// File: rtl/note_mixer.sv
// Twelve-note square-wave mixer: per-note tone generators summed at the audio
// sample rate and handed to the codec FIFO through a small write FSM.
module note_mixer #(
  parameter int          SAMPLE_DIV = 1042,
  parameter logic [31:0] AMPLITUDE  = 32'h0100_0000
) (
  input  logic          CLOCK_50,
  input  logic          nReset,
  input  logic [11:0]   select_note,
  input  logic          play_en,
  note_mixer_if.master  audio
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  localparam logic [16:0] HALF_PERIOD [12] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
    17'd67568, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619
  };

  typedef enum logic [1:0] {IDLE, SUM, WAIT, WRITE} state_t;

  logic [11:0]      sel_meta, sel_sync;
  logic             play_meta, play_sync;
  logic [11:0]      note_on;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [16:0]      tone_cnt [12];
  logic [11:0]      phase;
  logic [31:0]      mix;
  state_t           state;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      sel_meta  <= '0;
      sel_sync  <= '0;
      play_meta <= 1'b0;
      play_sync <= 1'b0;
    end else begin
      sel_meta  <= select_note;
      sel_sync  <= sel_meta;
      play_meta <= play_en;
      play_sync <= play_meta;
    end
  end

  assign note_on = sel_sync & {12{play_sync}};

  // Tick is registered so it is high in the cycle where the counter reads 0.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Disabled generators are parked at count 0 / phase 0 so a new note starts low.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 12; i++) tone_cnt[i] <= '0;
      phase <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (!note_on[i]) begin
          tone_cnt[i] <= '0;
          phase[i]    <= 1'b0;
        end else if (tone_cnt[i] == HALF_PERIOD[i] - 17'd1) begin
          tone_cnt[i] <= '0;
          phase[i]    <= ~phase[i];
        end else begin
          tone_cnt[i] <= tone_cnt[i] + 17'd1;
        end
      end
    end
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < 12; i++) begin
      if (note_on[i]) mix = phase[i] ? (mix + AMPLITUDE) : (mix - AMPLITUDE);
    end
  end

  // A tick arriving while a sample still waits for FIFO space replaces it and is counted as a drop.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state                         <= IDLE;
      audio.write_audio_out         <= 1'b0;
      audio.left_channel_audio_out  <= '0;
      audio.right_channel_audio_out <= '0;
      audio.dropped_count           <= '0;
    end else begin
      audio.write_audio_out <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= SUM;
        end
        SUM: begin
          audio.left_channel_audio_out  <= mix;
          audio.right_channel_audio_out <= mix;
          state                         <= WAIT;
        end
        WAIT: begin
          if (tick) begin
            audio.left_channel_audio_out  <= mix;
            audio.right_channel_audio_out <= mix;
            if (audio.dropped_count != 8'hFF)
              audio.dropped_count <= audio.dropped_count + 8'd1;
          end
          if (audio.audio_out_allowed) begin
            state                 <= WRITE;
            audio.write_audio_out <= 1'b1;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_mixer.sv
// Directed bench for note_mixer: a vector table of note/enable patterns with
// hand-computed mixes, plus sequences for latency, back-pressure, reset and tone toggling.
module tb_note_mixer;

  localparam int DIV = 16;

  logic        CLOCK_50 = 1'b0;
  logic        nReset   = 1'b0;
  logic [11:0] select_note = '0;
  logic        play_en  = 1'b0;

  note_mixer_if bus ();

  note_mixer #(.SAMPLE_DIV(DIV), .AMPLITUDE(32'h0100_0000)) dut (
    .CLOCK_50   (CLOCK_50),
    .nReset     (nReset),
    .select_note(select_note),
    .play_en    (play_en),
    .audio      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          back_to_back = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] last_left = '0;
  logic [31:0] last_right = '0;

  // Written samples are captured mid-cycle, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (bus.write_audio_out) begin
      wr_count++;
      last_left  = bus.left_channel_audio_out;
      last_right = bus.right_channel_audio_out;
      if (prev_wr) back_to_back++;
    end
    prev_wr = bus.write_audio_out;
  end

  typedef struct {
    string       name;
    logic [11:0] sel;
    logic        play;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [10];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic wait_write(input string name, input int budget);
    int c0;
    int k;
    c0 = wr_count;
    k  = 0;
    while (wr_count == c0 && k < budget) begin
      step(1);
      k++;
    end
    if (wr_count == c0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no write within %0d cycles", name, budget);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] sel, input logic play);
    select_note = sel;
    play_en     = play;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    step(2);
    nReset = 1'b1;
  endtask

  initial begin
    int edge_no;
    int found;
    int c0;

    vecs[0] = '{"silence_none",  12'h000, 1'b1, 32'h0000_0000};
    vecs[1] = '{"silence_play0", 12'hFFF, 1'b0, 32'h0000_0000};
    vecs[2] = '{"chord_start",   12'hFFF, 1'b1, 32'hF400_0000};
    vecs[3] = '{"note_c",        12'h001, 1'b1, 32'hFF00_0000};
    vecs[4] = '{"four_notes",    12'h0F0, 1'b1, 32'hFC00_0000};
    vecs[5] = '{"six_notes",     12'h555, 1'b1, 32'hFA00_0000};
    vecs[6] = '{"note_b",        12'h800, 1'b1, 32'hFF00_0000};
    vecs[7] = '{"two_notes",     12'h003, 1'b1, 32'hFE00_0000};
    vecs[8] = '{"play_off",      12'h003, 1'b0, 32'h0000_0000};
    vecs[9] = '{"note_a",        12'h200, 1'b1, 32'hFF00_0000};

    bus.audio_out_allowed = 1'b1;
    nReset = 1'b0;
    step(3);
    check_output("reset_write", {31'b0, bus.write_audio_out}, 32'd0);
    check_output("reset_left",  bus.left_channel_audio_out, 32'd0);
    check_output("reset_right", bus.right_channel_audio_out, 32'd0);
    check_output("reset_dropped", {24'b0, bus.dropped_count}, 32'd0);

    // First write lands three cycles after the first tick, DIV edges after release.
    nReset  = 1'b1;
    edge_no = 0;
    found   = 0;
    for (int i = 1; i <= 4 * DIV && found == 0; i++) begin
      step(1);
      if (bus.write_audio_out) begin
        found   = 1;
        edge_no = i;
      end
    end
    check_output("first_write_latency", edge_no, DIV + 3);
    step(1);
    check_output("strobe_width", {31'b0, bus.write_audio_out}, 32'd0);
    found = 0;
    for (int i = 1; i <= 4 * DIV && found == 0; i++) begin
      step(1);
      if (bus.write_audio_out) begin
        found   = 1;
        edge_no = i + 1;
      end
    end
    check_output("write_period", edge_no, DIV);

    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].sel, vecs[v].play);
      wait_write({vecs[v].name, "_settle"}, 4 * DIV);
      wait_write(vecs[v].name, 4 * DIV);
      check_output({vecs[v].name, "_left"},  last_left,  vecs[v].expected);
      check_output({vecs[v].name, "_right"}, last_right, vecs[v].expected);
    end

    // Note B: low until its half-period of 50619 cycles elapses, then high.
    apply_stimulus(12'h800, 1'b1);
    do_reset();
    step(50400);
    wait_write("tone_before_toggle", 4 * DIV);
    check_output("tone_before_toggle", last_left, 32'hFF00_0000);
    step(700);
    wait_write("tone_after_toggle", 4 * DIV);
    check_output("tone_after_toggle", last_left, 32'h0100_0000);

    // Back-pressure across three ticks with a different chord before each.
    bus.audio_out_allowed = 1'b0;
    apply_stimulus(12'h001, 1'b1);
    do_reset();
    c0 = wr_count;
    step(DIV + 5);
    apply_stimulus(12'h003, 1'b1);
    step(DIV);
    apply_stimulus(12'h007, 1'b1);
    step(DIV);
    check_output("bp_dropped", {24'b0, bus.dropped_count}, 32'd2);
    check_output("bp_held_left", bus.left_channel_audio_out, 32'hFD00_0000);
    check_output("bp_no_write_yet", wr_count - c0, 32'd0);
    c0 = wr_count;
    bus.audio_out_allowed = 1'b1;
    step(8);
    check_output("bp_write_count", wr_count - c0, 32'd1);
    check_output("bp_write_left",  last_left,  32'hFD00_0000);
    check_output("bp_write_right", last_right, 32'hFD00_0000);

    // 300 ticks with no FIFO space: the drop counter saturates and stays.
    bus.audio_out_allowed = 1'b0;
    do_reset();
    c0 = wr_count;
    step(300 * DIV + 5);
    check_output("sat_dropped", {24'b0, bus.dropped_count}, 32'd255);
    step(20 * DIV);
    check_output("sat_hold", {24'b0, bus.dropped_count}, 32'd255);
    check_output("sat_no_write", wr_count - c0, 32'd0);

    // Reset while parked in WAIT abandons the sample.
    #2;
    nReset = 1'b0;
    #1;
    check_output("rst_wait_write", {31'b0, bus.write_audio_out}, 32'd0);
    check_output("rst_wait_left",  bus.left_channel_audio_out, 32'd0);
    check_output("rst_wait_dropped", {24'b0, bus.dropped_count}, 32'd0);
    bus.audio_out_allowed = 1'b1;
    c0 = wr_count;
    step(4);
    check_output("rst_wait_no_strobe", wr_count - c0, 32'd0);
    nReset  = 1'b1;
    edge_no = 0;
    found   = 0;
    for (int i = 1; i <= 4 * DIV && found == 0; i++) begin
      step(1);
      if (bus.write_audio_out) begin
        found   = 1;
        edge_no = i;
      end
    end
    check_output("rst_release_latency", edge_no, DIV + 3);

    check_output("no_back_to_back", back_to_back, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
